scan_line_decoder: RTL and testbench

Parametrised, registered successor to the team's 2-to-4 line decoder with enable. Adds a selectable auto-scan mode: an internal prescaler and index counter step the one-hot output across all lines, e.g. for digit/row strobing of multiplexed displays. In manual mode it decodes an external select. Output polarity is set at elaboration. Sits between control logic and display/LED drive pins.

---
 rtl/scan_line_decoder_if.sv | 29 ++
 rtl/scan_line_decoder.sv | 111 +++++++++++
 tb/tb_scan_line_decoder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/scan_line_decoder_if.sv
// Bus bundle for scan_line_decoder: control inputs and decoded line outputs.
// There is no valid/ready handshake on this bus. Inputs are sampled on every
// rising clk edge. Outputs are registered and valid one cycle after the inputs
// that produced them.
interface scan_line_decoder_if #(
  parameter int SEL_W = 2,
  parameter int N_OUT = 4,
  parameter int DIV_W = 16
);
  logic             en;
  logic             mode;
  logic [SEL_W-1:0] sel_in;
  logic [DIV_W-1:0] div;
  logic [N_OUT-1:0] d;
  logic [SEL_W-1:0] cur_sel;
  logic             wrap;

  // Control logic side: drives the controls and observes the lines.
  modport master (
    output en, mode, sel_in, div,
    input  d, cur_sel, wrap
  );

  // Decoder side.
  modport slave (
    input  en, mode, sel_in, div,
    output d, cur_sel, wrap
  );
endinterface

// File: rtl/scan_line_decoder.sv
// Registered one-hot line decoder with manual select and auto-scan modes.
// In auto-scan mode, a prescaler steps an index across all N_OUT lines. Each
// line is held for div+1 cycles. wrap pulses when line 0 reappears after the
// last line. The output polarity is fixed at elaboration by ACTIVE_LOW.
module scan_line_decoder #(
  parameter int SEL_W      = 2,
  parameter int N_OUT      = 4,
  parameter int DIV_W      = 16,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  scan_line_decoder_if.slave   bus,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  localparam logic [N_OUT-1:0] ONE      = N_OUT'(1);
  localparam logic [N_OUT-1:0] INACTIVE = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_OUT - 1);
  localparam logic [SEL_W:0]   N_LIM    = (SEL_W + 1)'(N_OUT);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [SEL_W-1:0] cur_q, cur_d;
  // Set when the index wraps to 0. It is consumed when line 0 is next shown,
  // so that wrap lines up with the first cycle of line 0 on d.
  logic             pend_q, pend_d;
  logic             wrap_q, wrap_d;
  logic [N_OUT-1:0] d_q;
  logic [N_OUT-1:0] line_d;

  // The mode is reclassified every cycle from en/mode.
  // Next-state logic for the prescaler, index and lines.
  always_comb begin
    state_d = ST_IDLE;
    presc_d = presc_q;
    idx_d   = idx_q;
    cur_d   = cur_q;
    pend_d  = pend_q;
    wrap_d  = 1'b0;
    line_d  = '0;
    if (bus.en) begin
      state_d = bus.mode ? ST_SCAN : ST_MANUAL;
    end
    case (state_d)
      ST_MANUAL: begin
        presc_d = '0;
        idx_d   = '0;
        pend_d  = 1'b0;
        cur_d   = bus.sel_in;
        if ({1'b0, bus.sel_in} < N_LIM) begin
          line_d = ONE << bus.sel_in;
        end
      end
      ST_SCAN: begin
        line_d = ONE << idx_q;
        cur_d  = idx_q;
        wrap_d = pend_q;
        pend_d = 1'b0;
        // Using >= means that shrinking div below the current count steps at once.
        if (presc_q >= bus.div) begin
          presc_d = '0;
          if (idx_q == LAST_IDX) begin
            idx_d  = '0;
            pend_d = 1'b1;
          end else begin
            idx_d = idx_q + SEL_W'(1);
          end
        end else begin
          presc_d = presc_q + DIV_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // State and output registers; reset takes priority over every input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      idx_q   <= '0;
      cur_q   <= '0;
      pend_q  <= 1'b0;
      wrap_q  <= 1'b0;
      d_q     <= INACTIVE;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      wrap_q  <= wrap_d;
      d_q     <= line_d ^ INACTIVE;
    end
  end

  assign bus.d       = d_q;
  assign bus.cur_sel = cur_q;
  assign bus.wrap    = wrap_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_scan_line_decoder.sv
// Bench for scan_line_decoder. It drives two builds from the same stimulus:
// a 4-line active-high build and a 3-line active-low build.
module tb_scan_line_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        mode;
  logic [1:0]  sel;
  logic [15:0] div;
  logic [1:0]  state_a, state_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] exp_qa[$];
  logic [6:0] exp_qb[$];

  int m_presc[2];
  int m_idx[2];
  int m_cur[2];
  int m_pend[2];

  scan_line_decoder_if #(.SEL_W(2), .N_OUT(4), .DIV_W(16)) if_a ();
  scan_line_decoder_if #(.SEL_W(2), .N_OUT(3), .DIV_W(16)) if_b ();

  assign if_a.en = en;
  assign if_a.mode = mode;
  assign if_a.sel_in = sel;
  assign if_a.div = div;
  assign if_b.en = en;
  assign if_b.mode = mode;
  assign if_b.sel_in = sel;
  assign if_b.div = div;

  scan_line_decoder #(.SEL_W(2), .N_OUT(4), .DIV_W(16), .ACTIVE_LOW(0)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a), .state_o(state_a)
  );
  scan_line_decoder #(.SEL_W(2), .N_OUT(3), .DIV_W(16), .ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b), .state_o(state_b)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model of one clock edge for build id with n lines and polarity al.
  task automatic model_step(input int id, input int n, input bit al, output logic [6:0] e);
    int line;
    logic w;
    logic [3:0] dv;
    line = -1;
    w = 1'b0;
    if (rst) begin
      m_presc[id] = 0; m_idx[id] = 0; m_cur[id] = 0; m_pend[id] = 0;
    end else if (!en) begin
      line = -1;
    end else if (!mode) begin
      m_cur[id] = int'(sel);
      line = (int'(sel) < n) ? int'(sel) : -1;
      m_presc[id] = 0; m_idx[id] = 0; m_pend[id] = 0;
    end else begin
      line = m_idx[id];
      m_cur[id] = m_idx[id];
      w = (m_pend[id] != 0);
      m_pend[id] = 0;
      if (m_presc[id] >= int'(div)) begin
        m_presc[id] = 0;
        if (m_idx[id] == n - 1) begin
          m_idx[id] = 0;
          m_pend[id] = 1;
        end else begin
          m_idx[id] = m_idx[id] + 1;
        end
      end else begin
        m_presc[id] = m_presc[id] + 1;
      end
    end
    dv = (line >= 0) ? 4'(1 << line) : 4'd0;
    if (al) dv = dv ^ 4'((1 << n) - 1);
    e = {w, 2'(m_cur[id]), dv};
  endtask

  // Driver: push expected results for the coming edge, then compare after it.
  task automatic step();
    logic [6:0] ea, eb;
    model_step(0, 4, 1'b0, ea);
    model_step(1, 3, 1'b1, eb);
    exp_qa.push_back(ea);
    exp_qb.push_back(eb);
    @(posedge clk);
    #1;
    check("sb_a", 32'({if_a.wrap, if_a.cur_sel, if_a.d}), 32'(exp_qa.pop_front()));
    check("sb_b", 32'({if_b.wrap, if_b.cur_sel, 1'b0, if_b.d}), 32'(exp_qb.pop_front()));
  endtask

  initial begin
    int found;
    rst = 1'b1; en = 1'b1; mode = 1'b1; sel = 2'd0; div = 16'd2;

    // Reset.
    repeat (2) step();
    check("rst_d_a", 32'(if_a.d), 32'h0);
    check("rst_cur_a", 32'(if_a.cur_sel), 32'h0);
    check("rst_wrap_a", 32'(if_a.wrap), 32'h0);
    check("rst_d_b", 32'(if_b.d), 32'h7);
    check("rst_state", 32'(state_a), 32'h0);

    // Manual decode.
    rst = 1'b0; mode = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      step();
      check("man_d_a", 32'(if_a.d), 32'(1 << s));
      check("man_cur_a", 32'(if_a.cur_sel), 32'(s));
      if (s == 2) check("man_d_b2", 32'(if_b.d), 32'h3);
      if (s == 3) begin
        check("man_d_b3", 32'(if_b.d), 32'h7);
        check("man_cur_b3", 32'(if_b.cur_sel), 32'h3);
      end
    end
    check("man_state", 32'(state_a), 32'h1);
    en = 1'b0;
    step();
    check("en_off_d_a", 32'(if_a.d), 32'h0);
    check("en_off_cur_a", 32'(if_a.cur_sel), 32'h3);

    // Scan timing with div=2 over three full periods.
    en = 1'b1; sel = 2'd0;
    step();
    mode = 1'b1; div = 16'd2;
    for (int k = 0; k <= 36; k++) begin
      step();
      check("scan_d_a", 32'(if_a.d), 32'(1 << ((k / 3) % 4)));
      check("scan_wrap_a", 32'(if_a.wrap), 32'((k % 12 == 0) && (k > 0)));
    end
    check("scan_state", 32'(state_a), 32'h2);

    // Pause on line 2 with prescaler 5 of div 9, then resume and shrink div.
    mode = 1'b0;
    step();
    mode = 1'b1; div = 16'd9;
    repeat (25) step();
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("pause_d_a", 32'(if_a.d), 32'h0);
      check("pause_wrap_a", 32'(if_a.wrap), 32'h0);
    end
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("resume_d_a", 32'(if_a.d), 32'h4);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      check("line3_d_a", 32'(if_a.d), 32'h8);
    end
    div = 16'd1;
    step();
    check("shrink_d_a", 32'(if_a.d), 32'h8);
    step();
    check("shrink_step_a", 32'(if_a.d), 32'h1);
    check("shrink_wrap_a", 32'(if_a.wrap), 32'h1);

    // Reset while scanning on line 3.
    div = 16'd2;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      step();
      if (if_a.d == 4'h8) found = 1;
    end
    check("find_line3", 32'(found), 32'h1);
    rst = 1'b1;
    step();
    check("midrst_d_a", 32'(if_a.d), 32'h0);
    check("midrst_cur_a", 32'(if_a.cur_sel), 32'h0);
    check("midrst_d_b", 32'(if_b.d), 32'h7);
    rst = 1'b0;
    step();
    check("restart_d_a", 32'(if_a.d), 32'h1);
    check("restart_d_b", 32'(if_b.d), 32'h6);

    // div=0: one line per cycle, wrap every four cycles.
    mode = 1'b0;
    step();
    mode = 1'b1; div = 16'd0;
    for (int k = 0; k < 12; k++) begin
      step();
      check("fast_d_a", 32'(if_a.d), 32'(1 << (k % 4)));
      check("fast_wrap_a", 32'(if_a.wrap), 32'((k % 4 == 0) && (k > 0)));
    end

    // Maximum div: the line holds and the prescaler does not overflow.
    div = 16'hFFFF;
    repeat (6) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
